// File: rtl/ahb_slave_decoder.sv
// AHB-Lite address decoder and response mux for the DES (S0), config (S1) and default slaves.
// A stall watchdog ends a hung data phase with a forced two-cycle ERROR response.
module ahb_slave_decoder #(
  parameter logic [31:0] S0_BASE        = 32'h0000_0000,
  parameter logic [31:0] S0_MASK        = 32'hFFFF_F000,
  parameter logic [31:0] S1_BASE        = 32'h0000_1000,
  parameter logic [31:0] S1_MASK        = 32'hFFFF_FF00,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HREADYOUT_S0,
  input  logic        HREADYOUT_S1,
  input  logic        HREADYOUT_DEF,
  input  logic        HRESP_S0,
  input  logic        HRESP_S1,
  input  logic        HRESP_DEF,
  input  logic [63:0] HRDATA_S0,
  input  logic [63:0] HRDATA_S1,
  input  logic [63:0] HRDATA_DEF,
  output logic        HSEL_S0,
  output logic        HSEL_S1,
  output logic        HSEL_DEF,
  output logic        HREADY,
  output logic        HRESP,
  output logic [63:0] HRDATA,
  output logic        TIMEOUT
);

  typedef enum logic [1:0] {DSEL_NONE, DSEL_S0, DSEL_S1, DSEL_DEF} dsel_t;
  typedef enum logic [1:0] {ST_NORMAL, ST_ERR1, ST_ERR2} state_t;

  localparam logic [15:0] LP_TC_M1 = 16'(TIMEOUT_CYCLES - 1);

  dsel_t       r_dsel;
  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_timeout;

  logic        w_hit0;
  logic        w_hit1;
  dsel_t       w_dec;
  logic        w_sel_rdy;
  logic        w_sel_resp;
  logic [63:0] w_sel_data;
  logic        w_hready;

  // Priority S0 > S1 > DEF, so overlapping regions resolve to S0.
  assign w_hit0   = ((HADDR & S0_MASK) == S0_BASE);
  assign w_hit1   = ((HADDR & S1_MASK) == S1_BASE);
  assign HSEL_S0  = w_hit0;
  assign HSEL_S1  = !w_hit0 && w_hit1;
  assign HSEL_DEF = !w_hit0 && !w_hit1;

  always_comb begin
    w_dec = DSEL_DEF;
    if (w_hit0)      w_dec = DSEL_S0;
    else if (w_hit1) w_dec = DSEL_S1;
  end

  always_comb begin
    w_sel_rdy  = 1'b1;
    w_sel_resp = 1'b0;
    w_sel_data = '0;
    case (r_dsel)
      DSEL_S0: begin
        w_sel_rdy  = HREADYOUT_S0;
        w_sel_resp = HRESP_S0;
        w_sel_data = HRDATA_S0;
      end
      DSEL_S1: begin
        w_sel_rdy  = HREADYOUT_S1;
        w_sel_resp = HRESP_S1;
        w_sel_data = HRDATA_S1;
      end
      DSEL_DEF: begin
        w_sel_rdy  = HREADYOUT_DEF;
        w_sel_resp = HRESP_DEF;
        w_sel_data = HRDATA_DEF;
      end
      default: ;
    endcase
  end

  // During the forced error the hung slave's outputs are ignored entirely.
  always_comb begin
    w_hready = w_sel_rdy;
    HRESP    = w_sel_resp;
    HRDATA   = w_sel_data;
    case (r_state)
      ST_ERR1: begin
        w_hready = 1'b0;
        HRESP    = 1'b1;
        HRDATA   = '0;
      end
      ST_ERR2: begin
        w_hready = 1'b1;
        HRESP    = 1'b1;
        HRDATA   = '0;
      end
      default: ;
    endcase
  end

  assign HREADY  = w_hready;
  assign TIMEOUT = r_timeout;

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      r_dsel    <= DSEL_NONE;
      r_state   <= ST_NORMAL;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_NORMAL: begin
          if ((r_dsel != DSEL_NONE) && !w_sel_rdy) begin
            if (r_cnt == LP_TC_M1) begin
              r_state   <= ST_ERR1;
              r_timeout <= 1'b1;
              r_cnt     <= '0;
            end else if (r_cnt != 16'hFFFF) begin
              r_cnt <= r_cnt + 16'd1;
            end
          end else begin
            r_cnt <= '0;
          end
        end
        ST_ERR1: r_state <= ST_ERR2;
        ST_ERR2: begin
          r_state <= ST_NORMAL;
          r_cnt   <= '0;
        end
        default: r_state <= ST_NORMAL;
      endcase
      if (w_hready) r_dsel <= HTRANS[1] ? w_dec : DSEL_NONE;
    end
  end

endmodule
